// File: rtl/sr_latch_bank_if.sv
// sr_latch_bank_if: request/status bundle for the SR flag bank.
// The master drives set/reset requests; the slave returns registered state and pulses.
interface sr_latch_bank_if #(
   parameter int N     = 8,
   parameter int CNT_W = 8
);
   logic             in_en;
   logic [N-1:0]     in_s;
   logic [N-1:0]     in_r;
   logic             in_clr_err;
   logic [N-1:0]     out_q;
   logic [N-1:0]     out_q_bar;
   logic [N-1:0]     out_rise;
   logic [N-1:0]     out_fall;
   logic             out_conflict;
   logic [CNT_W-1:0] out_conflict_cnt;
   modport master (
      output in_en, in_s, in_r, in_clr_err,
      input  out_q, out_q_bar, out_rise, out_fall, out_conflict, out_conflict_cnt
   );
   modport slave (
      input  in_en, in_s, in_r, in_clr_err,
      output out_q, out_q_bar, out_rise, out_fall, out_conflict, out_conflict_cnt
   );
endinterface

// File: rtl/sr_latch_bank.sv
// sr_latch_bank: N clocked SR cells with a shared enable, edge pulses and
// forbidden-input (S=R=1) monitoring through a sticky flag and saturating counter.
module sr_latch_bank #(
   parameter int           N       = 8,
   parameter int           MODE    = 0,
   parameter logic [N-1:0] RST_VAL = '0,
   parameter int           CNT_W   = 8
) (
   input logic         clk,
   input logic         reset,
   sr_latch_bank_if.slave bus
);
   logic [N-1:0]     both;
   logic [N-1:0]     mode_val;
   logic [N-1:0]     q_next;
   logic             conflict_cyc;
   logic [CNT_W-1:0] cnt_next;
   always_comb begin
      both         = bus.in_s & bus.in_r;
      mode_val     = MODE == 0 ? '0 : MODE == 1 ? '1 : MODE == 2 ? bus.out_q : ~bus.out_q;
      q_next       = bus.in_en ? (bus.in_s & ~bus.in_r) | (~bus.in_s & ~bus.in_r & bus.out_q) | (both & mode_val)
                               : bus.out_q;
      conflict_cyc = bus.in_en & |both;
      // a conflict in the same cycle as a clear restarts the count at one
      cnt_next     = conflict_cyc ? (bus.in_clr_err ? CNT_W'(1)
                                     : &bus.out_conflict_cnt ? bus.out_conflict_cnt
                                     : bus.out_conflict_cnt + CNT_W'(1))
                   : bus.in_clr_err ? '0 : bus.out_conflict_cnt;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.out_q            <= RST_VAL;
         bus.out_q_bar        <= ~RST_VAL;
         bus.out_rise         <= '0;
         bus.out_fall         <= '0;
         bus.out_conflict     <= 1'b0;
         bus.out_conflict_cnt <= '0;
      end else begin
         bus.out_q            <= q_next;
         bus.out_q_bar        <= ~q_next;
         bus.out_rise         <= ~bus.out_q & q_next;
         bus.out_fall         <= bus.out_q & ~q_next;
         bus.out_conflict     <= conflict_cyc | (~bus.in_clr_err & bus.out_conflict);
         bus.out_conflict_cnt <= cnt_next;
      end
   end
endmodule
